dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port data memory between two requesters:
//  - Port 0: CPU data port.
//  - Port 1: loader/DMA engine.
//  Round-robin arbitration, at most one transaction in flight, fixed-latency read return.
//  Sits between the core's data bus (addr/data/mask/we/re) and the data RAM.
// PARAMETERS
//  ADDR_W  32  address width (byte address, passed through unchanged)
//  DATA_W  32  data width; mask width is DATA_W/8
//  RD_LAT  1   cycles from read issue to mem_rdata valid; legal range 1..7
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  reset      in   1         synchronous, active-high reset
//  req[1:0]   in   2         per-port request; held with its fields stable until gnt
//  we[1:0]    in   2         per-port write (1) / read (0)
//  addr0/1    in   ADDR_W    per-port byte address
//  wdata0/1   in   DATA_W    per-port write data, already lane-shifted
//  mask0/1    in   DATA_W/8  per-port byte-lane mask
//  gnt[1:0]   out  2         one-hot pulse: transaction accepted this cycle
//  rvalid[1:0] out 2         one-hot pulse: read data valid for that port
//  rdata      out  DATA_W    read data, meaningful only while rvalid != 0
//  mem_addr   out  ADDR_W    to RAM
//  mem_wdata  out  DATA_W    to RAM
//  mem_mask   out  DATA_W/8  to RAM
//  mem_we     out  1         to RAM
//  mem_re     out  1         to RAM
//  mem_rdata  in   DATA_W    from RAM, valid RD_LAT cycles after mem_re
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, mem_we=mem_re=0, mem_addr/wdata/mask=0, state=IDLE, last=1.
//   Port 0 therefore wins the first contention after reset.
//  States: IDLE, RD_WAIT. Counter cnt (3 bits) tracks RD_WAIT.
//  IDLE, req!=0 (issue cycle T):
//   - Pick winner: single requester wins; on both, winner = ~last.
//   - Drive mem_* combinationally from winner's fields; gnt[winner]=1; last<=winner.
//   - Write: mem_we=1; complete in T; stay IDLE (next issue allowed at T+1).
//   - Read: mem_re=1; owner<=winner; cnt<=1; go RD_WAIT.
//  IDLE, req==0: all mem_* enables 0, address/data buses 0.
//  RD_WAIT:
//   - No grants; mem_we=mem_re=0; cnt increments each cycle.
//   - At cnt==RD_LAT (cycle T+RD_LAT): rvalid[owner]=1, rdata=mem_rdata.
//   - That same cycle behaves as IDLE: a new grant/issue may occur.
//     Back-to-back reads: one per RD_LAT cycles.
//  rdata passes mem_rdata combinationally; zero when no rvalid.
//  Fairness: a continuously requesting port waits at most one other transaction.
//  gnt and rvalid never assert for both ports in one cycle; gnt and rvalid may
//   assert together (different or same port).
//  Requester dropping req before gnt: legal, no transaction.
//  req changing after gnt: ignored until next IDLE decision.
//  Reset mid-read: read discarded, no rvalid, state IDLE, last=1.
//  Assertions: gnt one-hot0; rvalid one-hot0; mem_we&mem_re never both 1;
//   RD_LAT in 1..7 (elaboration check).
// STRUCTURE
//  Package mem_bus_pkg:
//   - arb_state_t enum {ARB_IDLE, ARB_RD_WAIT}.
//   - Constants PORT_CPU=0, PORT_DMA=1.
//   - typedef mem_req_t struct {we, addr, wdata, mask}.
//  Sub-module rr_pick2 (combinational req[1:0] + last -> one-hot winner);
//   everything else inline.
// TESTING
//  1. Reset, then port0 read addr=0x10, RD_LAT=1, mem_rdata=0xDEADBEEF
//     -> gnt=01 at T, mem_re=1, mem_addr=0x10;
//     rvalid=01, rdata=0xDEADBEEF at T+1.
//  2. Both ports write at once after reset
//     -> port0 granted at T (mem_we=1, its mask), port1 at T+1; last=1 after.
//  3. Both hold read requests, RD_LAT=3 -> grants alternate 0,1,0 at T, T+3, T+6;
//     rvalid alternates at T+3, T+6, T+9, each coinciding with the next gnt.
//  4. Port1 write mask=0b1100 wdata=0x12340000 while port0 read in RD_WAIT
//     -> no gnt until the rvalid cycle; then gnt=10, mem_mask=1100.
//  5. Reset asserted at T+1 of a RD_LAT=3 read -> no rvalid ever;
//     outputs zero; next contention grants port0.
//  6. Port0 pulses req for one cycle during RD_WAIT then drops
//     -> no gnt, no memory access, state returns IDLE.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory bus between the core, the loader/DMA
// engine and the single-port data RAM.
package mem_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_MASK_W = BUS_DATA_W / 8;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DMA = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_MASK_W-1:0] mask;
    } mem_req_t;

    // Port index of a one-hot (or zero) two-port vector; zero maps to the CPU port.
    function automatic logic port_of(input logic [1:0] onehot);
        return onehot[PORT_DMA];
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on contention the port that did not
// win last time goes first.
module rr_pick2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? (2'b01 << PORT_CPU) : (2'b01 << PORT_DMA);
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU data port (0) and the loader/DMA engine
// (1): round-robin grant, one transaction in flight, fixed-latency read return.
module dmem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic [DATA_W/8-1:0] mask0,
    input  logic [DATA_W/8-1:0] mask1,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_W-1:0]   mem_rdata
);

    generate
        if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
            $error("dmem_arbiter: RD_LAT must be within 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT_CNT = 3'(RD_LAT);

    arb_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic [1:0] win;
    logic       rd_done;
    logic       can_issue;
    logic       sel;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt       = 2'b00;
        rvalid    = 2'b00;
        rdata     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rd_done   = (state_q == ARB_RD_WAIT) && (cnt_q == LAT_CNT);
        can_issue = (state_q == ARB_IDLE) || rd_done;
        sel       = port_of(win);

        // Outputs are held quiet while reset is asserted, so a reset mid-read never leaks rvalid.
        if (!reset) begin
            if (rd_done) begin
                rvalid[owner_q] = 1'b1;
                rdata           = mem_rdata;
                state_d         = ARB_IDLE;
            end else if (state_q == ARB_RD_WAIT) begin
                cnt_d = cnt_q + 3'd1;
            end

            // The read-return cycle doubles as an idle cycle, so a new issue can overlap it.
            if (can_issue && (req != 2'b00)) begin
                gnt       = win;
                last_d    = sel;
                mem_addr  = sel ? addr1 : addr0;
                mem_wdata = sel ? wdata1 : wdata0;
                mem_mask  = sel ? mask1 : mask0;
                mem_we    = we[sel];
                mem_re    = ~we[sel];
                if (!we[sel]) begin
                    state_d = ARB_RD_WAIT;
                    owner_d = sel;
                    cnt_d   = 3'd1;
                end
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt));
    a_rvalid_onehot0: assert property (@(posedge clk) $onehot0(rvalid));
    a_we_re_excl: assert property (@(posedge clk) !(mem_we && mem_re));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random two-port traffic against a transaction-level model; expected grants
// and read returns are queued at issue and matched by an independent monitor.
module tb_dmem_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned WORDS  = 16;

    typedef struct { mem_req_t r; int gap; int hold; } txn_t;
    typedef struct { int cyc; int port; mem_req_t r; } gnt_rec_t;
    typedef struct { int due; int port; logic [DATA_W-1:0] data; } rd_rec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req = 2'b00;
    logic [1:0]          we = 2'b00;
    logic [ADDR_W-1:0]   addr0 = '0;
    logic [ADDR_W-1:0]   addr1 = '0;
    logic [DATA_W-1:0]   wdata0 = '0;
    logic [DATA_W-1:0]   wdata1 = '0;
    logic [DATA_W/8-1:0] mask0 = '0;
    logic [DATA_W/8-1:0] mask1 = '0;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_mask;
    logic                mem_we;
    logic                mem_re;
    logic [DATA_W-1:0]   mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .mask0     (mask0),
        .mask1     (mask1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0137);
    endfunction

    // Data RAM behind the arbiter: masked writes, reads returned RD_LAT cycles after mem_re,
    // garbage on mem_rdata otherwise.
    logic [DATA_W-1:0] ram [WORDS];
    logic [DATA_W-1:0] pipe [RD_LAT];
    logic              ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        pipe[0] <= mem_re ? ram[mem_addr[5:2]] : $urandom;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata = pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    txn_t              pq [2][$];
    txn_t              cur [2];
    bit                act [2];
    int                held [2];
    bit                last_m = 1'b1;
    int                rd_due = 0;
    logic [DATA_W-1:0] ref_mem [WORDS];
    gnt_rec_t          gnt_q [$];
    rd_rec_t           rd_q [$];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, input int gap, input int hold);
        txn_t t;
        t.r.we    = w;
        t.r.addr  = a;
        t.r.wdata = d;
        t.r.mask  = m;
        t.gap     = gap;
        t.hold    = hold;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [3:0] idx;
        idx = 4'($urandom_range(0, WORDS - 1));
        return mk(1'($urandom_range(0, 1)), {26'd0, idx, 2'b00}, $urandom,
                  4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
    endfunction

    // One clock of stimulus plus the reference model's decision for that cycle.
    task automatic step(input bit rst);
        @(posedge clk);
        #1;
        reset = rst;
        for (int p = 0; p < 2; p++) begin
            if (act[p] && cur[p].hold != 0 && held[p] >= cur[p].hold) act[p] = 1'b0;
            if (!act[p] && pq[p].size() != 0) begin
                txn_t t;
                t = pq[p].pop_front();
                if (t.gap > 0) begin
                    t.gap--;
                    pq[p].push_front(t);
                end else begin
                    cur[p]  = t;
                    act[p]  = 1'b1;
                    held[p] = 0;
                end
            end
        end
        req    = {act[1], act[0]};
        we     = {act[1] ? cur[1].r.we : 1'($urandom), act[0] ? cur[0].r.we : 1'($urandom)};
        addr0  = act[0] ? cur[0].r.addr : $urandom;
        addr1  = act[1] ? cur[1].r.addr : $urandom;
        wdata0 = act[0] ? cur[0].r.wdata : $urandom;
        wdata1 = act[1] ? cur[1].r.wdata : $urandom;
        mask0  = act[0] ? cur[0].r.mask : 4'($urandom);
        mask1  = act[1] ? cur[1].r.mask : 4'($urandom);

        if (rst) begin
            last_m = 1'b1;
            rd_due = 0;
            rd_q.delete();
        end else if (cyc >= rd_due && req != 2'b00) begin
            int w;
            logic [3:0] idx;
            w   = (req == 2'b11) ? (last_m ? 0 : 1) : (req[1] ? 1 : 0);
            idx = cur[w].r.addr[5:2];
            last_m = (w == 1);
            gnt_q.push_back('{cyc: cyc, port: w, r: cur[w].r});
            if (cur[w].r.we) begin
                for (int b = 0; b < 4; b++)
                    if (cur[w].r.mask[b]) ref_mem[idx][8*b +: 8] = cur[w].r.wdata[8*b +: 8];
            end else begin
                rd_q.push_back('{due: cyc + int'(RD_LAT), port: w, data: ref_mem[idx]});
                rd_due = cyc + int'(RD_LAT);
            end
            act[w] = 1'b0;
        end
        for (int p = 0; p < 2; p++) if (act[p]) held[p]++;
    endtask

    // Monitor: compares DUT outputs each cycle against whatever the model queued for it.
    initial begin
        gnt_rec_t          g;
        rd_rec_t           d;
        bit                hit;
        logic [1:0]        exp_v;
        logic [DATA_W-1:0] exp_d;
        forever begin
            @(negedge clk);
            chk({gnt & (gnt - 2'd1), rvalid & (rvalid - 2'd1), mem_we & mem_re} == 5'd0,
                "onehot_excl", 128'({gnt, rvalid, mem_we, mem_re}), 128'(0));
            if (reset)
                chk({gnt, rvalid, rdata, mem_we, mem_re, mem_addr, mem_wdata, mem_mask} == '0,
                    "reset_outputs",
                    128'({gnt, rvalid, rdata, mem_we, mem_re, mem_addr, mem_wdata, mem_mask}),
                    128'(0));

            hit   = gnt_q.size() != 0 && gnt_q[0].cyc == cyc;
            exp_v = 2'b00;
            if (hit) begin
                g = gnt_q.pop_front();
                exp_v[g.port] = 1'b1;
            end
            chk(gnt == exp_v, "gnt", 128'(gnt), 128'(exp_v));
            if (hit && gnt == exp_v)
                chk({mem_we, mem_re, mem_addr, mem_wdata, mem_mask} ==
                    {g.r.we, ~g.r.we, g.r.addr, g.r.wdata, g.r.mask}, "issue_fields",
                    128'({mem_we, mem_re, mem_addr, mem_wdata, mem_mask}),
                    128'({g.r.we, ~g.r.we, g.r.addr, g.r.wdata, g.r.mask}));
            if (gnt == 2'b00)
                chk(!mem_we && !mem_re, "idle_enables", 128'({mem_we, mem_re}), 128'(0));
            if (req == 2'b00 && !reset)
                chk({mem_addr, mem_wdata, mem_mask} == '0, "idle_buses",
                    128'({mem_addr, mem_wdata, mem_mask}), 128'(0));

            hit   = rd_q.size() != 0 && rd_q[0].due == cyc;
            exp_v = 2'b00;
            exp_d = '0;
            if (hit) begin
                d = rd_q.pop_front();
                exp_v[d.port] = 1'b1;
                exp_d = d.data;
            end
            chk(rvalid == exp_v, "rvalid", 128'(rvalid), 128'(exp_v));
            chk(rdata == exp_d, "rdata", 128'(rdata), 128'(exp_d));
        end
    end

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        act[0] = 1'b0;
        act[1] = 1'b0;
        repeat (3) step(1'b1);

        // Lone CPU read of 0xDEADBEEF.
        pq[0].push_back(mk(1'b0, 32'h10, 32'h0, 4'hF, 0, 0));
        settle(6);

        // Simultaneous writes straight after reset: CPU first.
        repeat (2) step(1'b1);
        pq[0].push_back(mk(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011, 0, 0));
        pq[1].push_back(mk(1'b1, 32'h24, 32'h1122_3344, 4'b1111, 0, 0));
        settle(4);

        // Both ports streaming reads: grants alternate, each rvalid overlaps the next grant.
        for (int k = 0; k < 3; k++) begin
            pq[0].push_back(mk(1'b0, 32'h20, 32'h0, 4'hF, 0, 0));
            pq[1].push_back(mk(1'b0, 32'h24, 32'h0, 4'hF, 0, 0));
        end
        settle(24);

        // DMA write arrives during a CPU read; granted on the return cycle.
        pq[0].push_back(mk(1'b0, 32'h08, 32'h0, 4'hF, 0, 0));
        pq[1].push_back(mk(1'b1, 32'h08, 32'h1234_0000, 4'b1100, 1, 0));
        settle(8);

        // Reset one cycle into a read, then contention.
        pq[0].push_back(mk(1'b0, 32'h0C, 32'h0, 4'hF, 0, 0));
        step(1'b0);
        step(1'b1);
        step(1'b1);
        settle(4);
        pq[1].push_back(mk(1'b1, 32'h30, 32'h5555_AAAA, 4'b0101, 0, 0));
        pq[0].push_back(mk(1'b1, 32'h34, 32'h6666_BBBB, 4'b1010, 0, 0));
        settle(5);

        // CPU pulses a request for one cycle while the DMA read is outstanding.
        pq[1].push_back(mk(1'b0, 32'h30, 32'h0, 4'hF, 0, 0));
        pq[0].push_back(mk(1'b0, 32'h34, 32'h0, 4'hF, 1, 1));
        settle(8);

        for (int k = 0; k < 150; k++) begin
            pq[0].push_back(rand_txn());
            pq[1].push_back(rand_txn());
        end
        for (int i = 0; i < 4000 && (pq[0].size() != 0 || pq[1].size() != 0); i++)
            step($urandom_range(0, 199) == 0);
        for (int i = 0; i < 100 && (act[0] || act[1] || rd_q.size() != 0); i++) step(1'b0);
        settle(RD_LAT + 2);
        @(negedge clk);
        #1;
        chk(gnt_q.size() == 0 && rd_q.size() == 0 && !act[0] && !act[1], "drained",
            128'({gnt_q.size(), rd_q.size()}), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
